player2_link_rx: RTL and testbench



---
 rtl/link_pkg.sv | 37 +++
 rtl/link_watchdog.sv | 30 +++
 rtl/player2_link_rx.sv | 172 +++++++++++++++++
 tb/tb_player2_link_rx.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/link_pkg.sv
// Shared constants and types for the partner-board status link.
// The bit positions are used by both the receiver and the transmitter.
package link_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam int         PAYLOAD_LEN = 6;
  localparam int         IDX_W       = $clog2(PAYLOAD_LEN);

  typedef enum logic [1:0] {
    HUNT,
    PAYLOAD,
    CHECK
  } rx_state_t;

  // P1 = {x[3:0], y[11:8]}
  localparam int P1_X_LO_MSB  = 7;
  localparam int P1_X_LO_LSB  = 4;
  localparam int P1_Y_HI_MSB  = 3;
  localparam int P1_Y_HI_LSB  = 0;

  // P3 = {hp, aggro}
  localparam int P3_HP_MSB    = 7;
  localparam int P3_HP_LSB    = 4;
  localparam int P3_AGGRO_MSB = 3;
  localparam int P3_AGGRO_LSB = 0;

  // P4 = {flip_h, class[1:0], game_start, 4'b0}
  localparam int P4_FLIP_BIT  = 7;
  localparam int P4_CLASS_MSB = 6;
  localparam int P4_CLASS_LSB = 5;
  localparam int P4_START_BIT = 4;

  // P5 = {1'b0, boss_hp[6:0]}
  localparam int P5_BOSS_MSB  = 6;
  localparam int P5_BOSS_LSB  = 0;

endpackage

// File: rtl/link_watchdog.sv
// Loadable down-counter with an expiry flag. It saturates at zero.
// The flag is high while the count is zero.
module link_watchdog #(
  parameter int LOAD_VALUE = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(LOAD_VALUE + 1);

  logic [W-1:0] count_reg;

  // Reload takes priority over counting; counting stops at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= W'(LOAD_VALUE);
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign expired = (count_reg == '0);

endmodule

// File: rtl/player2_link_rx.sv
// Status-frame receiver for the partner board.
// It hunts for the sync byte and buffers the six payload bytes.
// It checks the XOR checksum and commits good frames to registered outputs.
// It drops data_valid when no good frame arrives within the link timeout.
module player2_link_rx
  import link_pkg::*;
#(
  parameter int BYTE_GAP_CYCLES     = 65_000,
  parameter int LINK_TIMEOUT_CYCLES = 6_500_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [11:0] player_2_x,
  output logic [11:0] player_2_y,
  output logic [3:0]  player_2_hp,
  output logic [3:0]  player_2_aggro,
  output logic        player_2_flip_h,
  output logic [1:0]  player_2_class,
  output logic        player2_game_start,
  output logic [6:0]  boss_out_hp,
  output logic        player_2_data_valid,
  output logic        frame_ok,
  output logic        frame_err
);

  rx_state_t        state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [7:0]       xor_reg, xor_next;
  logic [7:0]       shadow_reg [PAYLOAD_LEN];

  logic shadow_we;
  logic commit;
  logic err;
  logic gap_expired;
  logic link_expired;

  // Byte-gap timer: re-armed by every byte, counts only inside a frame.
  link_watchdog #(
    .LOAD_VALUE (BYTE_GAP_CYCLES)
  ) u_gap_wdt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (rx_valid),
    .en      (state_reg != HUNT),
    .expired (gap_expired)
  );

  // Link timer: re-armed by each committed frame.
  link_watchdog #(
    .LOAD_VALUE (LINK_TIMEOUT_CYCLES)
  ) u_link_wdt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (commit),
    .en      (1'b1),
    .expired (link_expired)
  );

  // State, byte index and running XOR registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= HUNT;
      idx_reg   <= '0;
      xor_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      xor_reg   <= xor_next;
    end
  end

  // Framing decisions. An arriving byte always beats gap expiry in the same cycle.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    xor_next   = xor_reg;
    shadow_we  = 1'b0;
    commit     = 1'b0;
    err        = 1'b0;
    case (state_reg)
      HUNT: begin
        if (rx_valid && (rx_byte == SYNC_BYTE)) begin
          idx_next   = '0;
          xor_next   = '0;
          state_next = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (rx_valid) begin
          // A sync value here is plain data; there is no resync mid-frame.
          shadow_we = 1'b1;
          xor_next  = xor_reg ^ rx_byte;
          if (idx_reg == IDX_W'(PAYLOAD_LEN - 1)) begin
            state_next = CHECK;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end else if (gap_expired) begin
          err        = 1'b1;
          state_next = HUNT;
        end
      end
      CHECK: begin
        if (rx_valid) begin
          if (rx_byte == xor_reg) begin
            commit = 1'b1;
          end else begin
            err = 1'b1;
          end
          state_next = HUNT;
        end else if (gap_expired) begin
          err        = 1'b1;
          state_next = HUNT;
        end
      end
      default: begin
        state_next = HUNT;
      end
    endcase
  end

  // Shadow buffer: holds the payload until the checksum confirms it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PAYLOAD_LEN; i++) begin
        shadow_reg[i] <= '0;
      end
    end else if (shadow_we) begin
      shadow_reg[idx_reg] <= rx_byte;
    end
  end

  // The reserved bits of P4 and P5 are deliberately ignored.
  logic unused_reserved;
  assign unused_reserved = ^{shadow_reg[4][3:0], shadow_reg[5][7]};

  // Output registers. Fields change only on commit; a commit beats link expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      player_2_x          <= '0;
      player_2_y          <= '0;
      player_2_hp         <= '0;
      player_2_aggro      <= '0;
      player_2_flip_h     <= 1'b0;
      player_2_class      <= '0;
      player2_game_start  <= 1'b0;
      boss_out_hp         <= '0;
      player_2_data_valid <= 1'b0;
      frame_ok            <= 1'b0;
      frame_err           <= 1'b0;
    end else begin
      frame_ok  <= commit;
      frame_err <= err;
      if (commit) begin
        player_2_x          <= {shadow_reg[0], shadow_reg[1][P1_X_LO_MSB:P1_X_LO_LSB]};
        player_2_y          <= {shadow_reg[1][P1_Y_HI_MSB:P1_Y_HI_LSB], shadow_reg[2]};
        player_2_hp         <= shadow_reg[3][P3_HP_MSB:P3_HP_LSB];
        player_2_aggro      <= shadow_reg[3][P3_AGGRO_MSB:P3_AGGRO_LSB];
        player_2_flip_h     <= shadow_reg[4][P4_FLIP_BIT];
        player_2_class      <= shadow_reg[4][P4_CLASS_MSB:P4_CLASS_LSB];
        player2_game_start  <= shadow_reg[4][P4_START_BIT];
        boss_out_hp         <= shadow_reg[5][P5_BOSS_MSB:P5_BOSS_LSB];
        player_2_data_valid <= 1'b1;
      end else if (link_expired) begin
        player_2_data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_player2_link_rx.sv
// Directed bench for player2_link_rx. It has a frame table plus hand sequences
// for gap expiry, link timeout, same-cycle races and mid-frame reset.
module tb_player2_link_rx;

  localparam int GAP = 16;
  localparam int TMO = 120;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_valid = 1'b0;
  logic [11:0] player_2_x;
  logic [11:0] player_2_y;
  logic [3:0]  player_2_hp;
  logic [3:0]  player_2_aggro;
  logic        player_2_flip_h;
  logic [1:0]  player_2_class;
  logic        player2_game_start;
  logic [6:0]  boss_out_hp;
  logic        player_2_data_valid;
  logic        frame_ok;
  logic        frame_err;

  player2_link_rx #(
    .BYTE_GAP_CYCLES     (GAP),
    .LINK_TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .rx_byte             (rx_byte),
    .rx_valid            (rx_valid),
    .player_2_x          (player_2_x),
    .player_2_y          (player_2_y),
    .player_2_hp         (player_2_hp),
    .player_2_aggro      (player_2_aggro),
    .player_2_flip_h     (player_2_flip_h),
    .player_2_class      (player_2_class),
    .player2_game_start  (player2_game_start),
    .boss_out_hp         (boss_out_hp),
    .player_2_data_valid (player_2_data_valid),
    .frame_ok            (frame_ok),
    .frame_err           (frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int ok_pulses = 0;
  int err_pulses = 0;
  logic arm_drop = 1'b0;
  logic dropped = 1'b0;

  // Count pulses and watch for data_valid drops, sampled away from the active edge.
  always @(negedge clk) begin
    if (frame_ok) ok_pulses++;
    if (frame_err) err_pulses++;
    if (arm_drop && !player_2_data_valid) dropped = 1'b1;
  end

  typedef struct {
    logic [63:0] frame;
    logic        exp_ok;
    logic [42:0] exp_fields;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [42:0] pack(input logic [11:0] x, input logic [11:0] y,
                                       input logic [3:0] hp, input logic [3:0] ag,
                                       input logic f, input logic [1:0] c,
                                       input logic gs, input logic [6:0] boss);
    return {x, y, hp, ag, f, c, gs, boss};
  endfunction

  function automatic logic [42:0] dut_fields();
    return {player_2_x, player_2_y, player_2_hp, player_2_aggro, player_2_flip_h,
            player_2_class, player2_game_start, boss_out_hp};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  // Each byte is driven on a falling edge. idle sets the empty cycles between bytes.
  // On return we sit one half-cycle after the edge that sampled the checksum.
  task automatic send_frame(input logic [63:0] frame, input int idle);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_byte  = frame[63-8*i -: 8];
      if (i < 7) begin
        for (int k = 0; k < idle; k++) begin
          @(negedge clk);
          rx_valid = 1'b0;
        end
      end
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_byte  = b;
  endtask

  initial begin
    logic [42:0] f1;
    logic [42:0] f3;
    logic [42:0] f4;
    logic [42:0] f5;
    int e0;
    int o0;
    int first;

    f1 = pack(12'h123, 12'h2A8, 4'd5, 4'd3, 1'b1, 2'd2, 1'b1, 7'd100);
    f3 = pack(12'h000, 12'h000, 4'd0, 4'd0, 1'b0, 2'd0, 1'b0, 7'd0);
    f4 = pack(12'hFFF, 12'hFFF, 4'hF, 4'hF, 1'b1, 2'd3, 1'b1, 7'd127);
    f5 = pack(12'hA55, 12'hAA5, 4'd2, 4'd1, 1'b0, 2'd1, 1'b0, 7'd5);

    vecs[0] = '{64'hA5_12_32_A8_53_D0_64_6F, 1'b1, f1};
    vecs[1] = '{64'hA5_12_32_A8_53_D0_64_6E, 1'b0, f1};
    vecs[2] = '{64'hA5_00_00_00_00_00_00_00, 1'b1, f3};
    vecs[3] = '{64'hA5_FF_FF_FF_FF_FF_7F_80, 1'b1, f4};
    vecs[4] = '{64'hA5_A5_5A_A5_21_20_85_DE, 1'b1, f5};
    vecs[5] = '{64'hA5_A5_5A_A5_21_20_85_DF, 1'b0, f5};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_fields", 64'(dut_fields()), 64'd0);
    chk("reset_pulses_valid", {61'd0, frame_ok, frame_err, player_2_data_valid}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven frames
    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].frame, 0);
      chk($sformatf("v%0d_frame_ok", v), 64'(frame_ok), 64'(vecs[v].exp_ok));
      chk($sformatf("v%0d_frame_err", v), 64'(frame_err), 64'(!vecs[v].exp_ok));
      chk($sformatf("v%0d_fields", v), 64'(dut_fields()), 64'(vecs[v].exp_fields));
      chk($sformatf("v%0d_data_valid", v), 64'(player_2_data_valid), 64'd1);
      @(negedge clk);
      chk($sformatf("v%0d_pulse_width", v), {62'd0, frame_ok, frame_err}, 64'd0);
    end

    // Garbage bytes are dropped silently; the frame that follows is accepted
    e0 = err_pulses;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h13);
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("garbage_no_err", 64'(err_pulses - e0), 64'd0);
    send_frame(vecs[0].frame, 0);
    chk("after_garbage_ok", 64'(frame_ok), 64'd1);
    chk("after_garbage_fields", 64'(dut_fields()), 64'(f1));

    // A truncated frame times out on the byte gap
    send_byte(8'hA5);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    first = -1;
    for (int k = 1; k <= GAP + 4; k++) begin
      @(negedge clk);
      rx_valid = 1'b0;
      if (frame_err && first < 0) first = k;
    end
    chk_range("gap_err_cycle", first, GAP, GAP + 2);
    chk("gap_fields_hold", 64'(dut_fields()), 64'(f1));
    send_frame(vecs[3].frame, 0);
    chk("after_gap_ok", 64'(frame_ok), 64'd1);
    chk("after_gap_fields", 64'(dut_fields()), 64'(f4));

    // A byte arriving exactly when the gap expires is accepted, with no error
    e0 = err_pulses;
    send_frame(vecs[2].frame, GAP);
    chk("gap_race_ok", 64'(frame_ok), 64'd1);
    chk("gap_race_fields", 64'(dut_fields()), 64'(f3));
    chk("gap_race_no_err", 64'(err_pulses - e0), 64'd0);

    // Link timeout drops data_valid; the fields hold
    send_frame(vecs[0].frame, 0);
    first = -1;
    for (int k = 1; k <= TMO + 3; k++) begin
      @(negedge clk);
      if (!player_2_data_valid && first < 0) first = k;
    end
    chk_range("link_timeout_cycle", first, TMO, TMO + 2);
    chk("timeout_fields_hold", 64'(dut_fields()), 64'(f1));
    send_frame(vecs[4].frame, 0);
    chk("relink_valid", 64'(player_2_data_valid), 64'd1);

    // A commit in the expiry cycle keeps data_valid high
    dropped = 1'b0;
    arm_drop = 1'b1;
    repeat (TMO - 8) @(negedge clk);
    send_frame(vecs[3].frame, 0);
    arm_drop = 1'b0;
    chk("expiry_race_ok", 64'(frame_ok), 64'd1);
    chk("expiry_race_no_drop", 64'(dropped), 64'd0);
    chk("expiry_race_valid", 64'(player_2_data_valid), 64'd1);

    // Reset after P3 clears everything; the rest of that frame must not commit
    send_byte(8'hA5);
    send_byte(8'h12);
    send_byte(8'h32);
    send_byte(8'hA8);
    send_byte(8'h53);
    @(negedge clk);
    rx_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midreset_fields", 64'(dut_fields()), 64'd0);
    chk("midreset_pulses_valid", {61'd0, frame_ok, frame_err, player_2_data_valid}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    e0 = err_pulses;
    o0 = ok_pulses;
    send_byte(8'hD0);
    send_byte(8'h64);
    send_byte(8'h6F);
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("tail_no_pulses", 64'((err_pulses - e0) + (ok_pulses - o0)), 64'd0);
    chk("tail_fields_zero", 64'(dut_fields()), 64'd0);
    send_frame(vecs[4].frame, 0);
    chk("post_reset_ok", 64'(frame_ok), 64'd1);
    chk("post_reset_fields", 64'(dut_fields()), 64'(f5));
    chk("post_reset_valid", 64'(player_2_data_valid), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety bound so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

endmodule
